theta_func: RTL

Theta (column-parity diffusion) stage of the matrix encoder. It reads the 64 × 25-bit slice memory through the same read interface the other stages use (`cnt_value` address out, `line_in` data in). For each slice it XORs two neighbouring column parities into every bit, and streams the 64 result slices out on `write_enable`/`write_value`. It sits directly upstream of the permutation stage and produces the slice file that stage consumes.

---
 rtl/theta_func.sv | 121 ++++++++++++
 1 files changed

// File: rtl/theta_func.sv
// Theta column-parity diffusion stage: reads 64 x 25-bit slices and streams
// each slice XORed with neighbouring column parities, one write pulse per slice.
module theta_func (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [5:0]  cnt_value,
   input  logic [24:0] line_in,
   output logic        write_enable,
   output logic [24:0] write_value,
   output logic [5:0]  write_addr,
   output logic        donee
);

   typedef enum logic [2:0] {StIdle, StPre, StCalc, StEmit, StFin} state_e;

   state_e      r_state, w_state_d;
   logic [4:0]  r_cprev, w_cprev_d;
   logic [5:0]  r_z, w_z_d;
   logic        r_we, w_we_d;
   logic        r_donee, w_donee_d;
   logic [24:0] r_wval, w_wval_d;
   logic [5:0]  r_waddr, w_waddr_d;

   logic [4:0]  w_col;
   logic [4:0]  w_dmix;
   logic [24:0] w_theta;

   // Column parity of the current slice and the per-column mixing term D[x].
   always_comb begin
      w_col  = '0;
      w_dmix = '0;
      w_theta = '0;
      for (int x = 0; x < 5; x++) begin
         w_col[x] = line_in[x] ^ line_in[x+5] ^ line_in[x+10] ^ line_in[x+15] ^ line_in[x+20];
      end
      for (int x = 0; x < 5; x++) begin
         w_dmix[x] = w_col[(x + 4) % 5] ^ r_cprev[(x + 1) % 5];
      end
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            w_theta[5*y+x] = line_in[5*y+x] ^ w_dmix[x];
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cprev_d = r_cprev;
      w_z_d     = r_z;
      w_we_d    = r_we;
      w_donee_d = r_donee;
      w_wval_d  = r_wval;
      w_waddr_d = r_waddr;
      cnt_value = 6'd0;
      unique case (r_state)
         StIdle: begin
            if (start) w_state_d = StPre;
         end
         StPre: begin
            // Pre-read slice 63 so slice 0 sees the wrapped z-1 parity.
            cnt_value = 6'd63;
            w_cprev_d = w_col;
            w_z_d     = 6'd0;
            w_state_d = StCalc;
         end
         StCalc: begin
            cnt_value = r_z;
            w_wval_d  = w_theta;
            w_waddr_d = r_z;
            w_we_d    = 1'b1;
            w_cprev_d = w_col;
            w_state_d = StEmit;
         end
         StEmit: begin
            cnt_value = r_z;
            w_we_d    = 1'b0;
            if (r_z == 6'd63) begin
               w_donee_d = 1'b1;
               w_state_d = StFin;
            end else begin
               w_z_d     = r_z + 6'd1;
               w_state_d = StCalc;
            end
         end
         StFin: begin
            if (!start) begin
               w_donee_d = 1'b0;
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_cprev <= '0;
         r_z     <= '0;
         r_we    <= 1'b0;
         r_donee <= 1'b0;
         r_wval  <= '0;
         r_waddr <= '0;
      end else begin
         r_state <= w_state_d;
         r_cprev <= w_cprev_d;
         r_z     <= w_z_d;
         r_we    <= w_we_d;
         r_donee <= w_donee_d;
         r_wval  <= w_wval_d;
         r_waddr <= w_waddr_d;
      end
   end

   assign write_enable = r_we;
   assign write_value  = r_wval;
   assign write_addr   = r_waddr;
   assign donee        = r_donee;

endmodule
